fb_slot_arbiter: RTL and testbench
==================================

Name: fb_slot_arbiter

Overview:
- Parametrised frame-buffer port arbiter for the single-port on-chip frame buffer.
- Time-multiplexes one display read slot and three write slots over a repeating 4-cycle phase schedule.
- Serves N_CH raytracer cores with valid/ready handshakes and round-robin arbitration.
- Each core owns an interleaved pixel column set and gets its next pixel coordinate from a per-channel cursor kept inside this block.

Parameters:
- H_RES, 640, visible pixels per line; must be a multiple of N_CH.
- V_RES, 480, visible lines per frame.
- PIX_W, 4, frame-buffer pixel width in bits.
- N_CH, 2, number of raytracer write channels (1..8).
- ADDR_W, 19, frame-buffer address width; must satisfy 2^ADDR_W >= H_RES*V_RES.
- XY_W, 10, width of each X and Y coordinate.

Ports:
- CLK  in  1  system clock.
- RESET  in  1  asynchronous, active-high reset.
- DRAW_X  in  XY_W  display pixel column from the VGA controller.
- DRAW_Y  in  XY_W  display pixel row.
- PIX_OUT  out  PIX_W  registered display pixel read from the frame buffer.
- WR_VALID  in  N_CH  per-channel "pixel result available".
- WR_DATA  in  N_CH*PIX_W  per-channel pixel value; channel c occupies bits [c*PIX_W +: PIX_W].
- WR_READY  out  N_CH  one-hot grant; asserted for one cycle when the channel's pixel is written.
- CH_X  out  N_CH*XY_W  per-channel cursor column the core must compute next.
- CH_Y  out  N_CH*XY_W  per-channel cursor row.
- FRAME_DONE  out  N_CH  one-cycle pulse when a channel writes its last pixel of the frame.
- MEM_ADDR  out  ADDR_W  frame-buffer address.
- MEM_WDATA  out  PIX_W  frame-buffer write data.
- MEM_WE  out  1  frame-buffer write enable.
- MEM_RDATA  in  PIX_W  frame-buffer read data; 1-cycle registered-output latency.

Behaviour:
- Reset values:
  - PHASE = 0; PIX_OUT = 0; RR_PTR = 0.
  - Channel c cursor: X = c, Y = 0.
  - FRAME_DONE = 0; WR_READY = 0; MEM_WE = 0.
- Phase counter: 2 bits, increments every cycle, wraps 3 -> 0, free-running.
- Phase 0 (read issue):
  - MEM_ADDR = DRAW_X + H_RES*DRAW_Y, truncated to ADDR_W.
  - MEM_WE = 0. No grants.
- Phases 1, 2, 3 (write slots):
  - Arbiter scans channels RR_PTR, RR_PTR+1, ... mod N_CH and grants the first with WR_VALID = 1.
  - On grant g: WR_READY[g] = 1 (combinational, same cycle); MEM_WE = 1; MEM_WDATA = WR_DATA[g]; MEM_ADDR = CH_X[g] + H_RES*CH_Y[g]; RR_PTR <= (g+1) mod N_CH.
  - No valid channel: MEM_WE = 0, MEM_ADDR = 0, MEM_WDATA = 0, RR_PTR unchanged.
- Phase 1 only: PIX_OUT <= MEM_RDATA, capturing the phase-0 read. PIX_OUT then holds for 4 cycles.
- Handshake:
  - Transfer occurs on the cycle where WR_VALID[c] && WR_READY[c].
  - WR_VALID must not depend combinationally on WR_READY.
  - A core holds WR_VALID and WR_DATA stable until the transfer.
  - At most one channel is granted per cycle.
- Cursor advance, on transfer of channel c only:
  - X <= X + N_CH.
  - If X + N_CH >= H_RES: X <= c and Y <= Y + 1.
  - If Y was also V_RES-1: Y <= 0 and FRAME_DONE[c] pulses for the following cycle.
  - Cursors are registered outputs and change the cycle after the transfer.
- Fairness: with all channels continuously valid, grants rotate 0,1,..,N_CH-1 across consecutive write slots, including across phase-0 gaps.
- Display path: always reads, independent of blanking. The VGA output stage applies blanking.
- Reset asserted mid-frame: all state returns to reset values immediately. Partially written frame contents are left in memory, and rendering restarts at pixel (c,0) for each channel.
- Width rule: address arithmetic is computed at ADDR_W+1 bits, then truncated. Out-of-range DRAW_X/DRAW_Y are not checked.

Test Plan:
- Reset, all WR_VALID = 0, DRAW_X = 5, DRAW_Y = 2 -> MEM_ADDR = 1285 in phase 0 every 4 cycles; MEM_WE never 1; PIX_OUT equals MEM_RDATA from the cycle after phase 0.
- N_CH = 2, only ch0 valid with data 4'hA -> writes at phases 1, 2, 3 to addresses 0, 2, 4; CH_X[0] = 2 after the first transfer; CH_X[1] stays 1.
- N_CH = 2, both valid continuously -> grants alternate 0,1,0 | 1,0,1 across consecutive frames of phases 1-3; addresses for ch1 are 1, 3, 5.
- Ch0 cursor preset by driving transfers to X = 638, Y = 479, then one more transfer -> next cycle X = 0, Y = 0, FRAME_DONE[0] = 1 for exactly 1 cycle.
- Ch1 valid and held, then RESET pulsed during phase 2 -> all outputs return to reset values asynchronously; after release, the first ch1 write goes to address 1 in phase 1.
- WR_VALID held with WR_READY = 0 during phase 0 -> no write occurs, WR_DATA is retained, and the transfer happens in the next phase 1.

Source files
------------

// File: rtl/fb_slot_arbiter.sv
// Single-port frame-buffer arbiter: one display read slot and three round-robin write
// slots per 4-cycle phase, with a per-channel interleaved pixel cursor for each core.
module fb_slot_arbiter #(
    parameter int H_RES  = 640,
    parameter int V_RES  = 480,
    parameter int PIX_W  = 4,
    parameter int N_CH   = 2,
    parameter int ADDR_W = 19,
    parameter int XY_W   = 10
) (
    input  logic                   clk_i,
    input  logic                   reset_i,
    input  logic [XY_W-1:0]        draw_x_i,
    input  logic [XY_W-1:0]        draw_y_i,
    output logic [PIX_W-1:0]       pix_out_o,
    input  logic [N_CH-1:0]        wr_valid_i,
    input  logic [N_CH*PIX_W-1:0]  wr_data_i,
    output logic [N_CH-1:0]        wr_ready_o,
    output logic [N_CH*XY_W-1:0]   ch_x_o,
    output logic [N_CH*XY_W-1:0]   ch_y_o,
    output logic [N_CH-1:0]        frame_done_o,
    output logic [ADDR_W-1:0]      mem_addr_o,
    output logic [PIX_W-1:0]       mem_wdata_o,
    output logic                   mem_we_o,
    input  logic [PIX_W-1:0]       mem_rdata_i
);

    localparam int CH_W = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam int AW1  = ADDR_W + 1;

    // One guard bit keeps the intermediate sum from wrapping before truncation.
    function automatic logic [ADDR_W-1:0] pix_addr(input logic [XY_W-1:0] x,
                                                   input logic [XY_W-1:0] y);
        logic [AW1-1:0] sum;
        sum = AW1'(x) + AW1'(H_RES) * AW1'(y);
        return sum[ADDR_W-1:0];
    endfunction

    logic [1:0]       phase_q;
    logic [CH_W-1:0]  rr_ptr_q;
    logic [PIX_W-1:0] pix_out_q;

    logic [XY_W-1:0]  cur_x [N_CH];
    logic [XY_W-1:0]  cur_y [N_CH];

    logic             gnt_valid;
    logic [CH_W-1:0]  gnt_idx;
    int               scan_idx;

    always_comb begin
        gnt_valid = 1'b0;
        gnt_idx   = '0;
        scan_idx  = 0;
        if (phase_q != 2'd0) begin
            for (int k = 0; k < N_CH; k++) begin
                scan_idx = int'(rr_ptr_q) + k;
                if (scan_idx >= N_CH) begin
                    scan_idx = scan_idx - N_CH;
                end
                if (!gnt_valid && wr_valid_i[scan_idx]) begin
                    gnt_valid = 1'b1;
                    gnt_idx   = CH_W'(scan_idx);
                end
            end
        end
    end

    assign wr_ready_o = gnt_valid ? (N_CH'(1) << gnt_idx) : '0;

    always_comb begin
        mem_addr_o  = '0;
        mem_wdata_o = '0;
        mem_we_o    = 1'b0;
        if (phase_q == 2'd0) begin
            mem_addr_o = pix_addr(draw_x_i, draw_y_i);
        end else if (gnt_valid) begin
            mem_we_o    = 1'b1;
            mem_wdata_o = wr_data_i[gnt_idx*PIX_W +: PIX_W];
            mem_addr_o  = pix_addr(cur_x[gnt_idx], cur_y[gnt_idx]);
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            phase_q   <= 2'd0;
            rr_ptr_q  <= '0;
            pix_out_q <= '0;
        end else begin
            phase_q <= phase_q + 2'd1;
            if (gnt_valid) begin
                rr_ptr_q <= (int'(gnt_idx) == N_CH - 1) ? '0 : gnt_idx + CH_W'(1);
            end
            // Read data for the phase-0 address arrives during phase 1.
            if (phase_q == 2'd1) begin
                pix_out_q <= mem_rdata_i;
            end
        end
    end

    assign pix_out_o = pix_out_q;

    for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
        logic [XY_W-1:0] x_q;
        logic [XY_W-1:0] y_q;
        logic            done_q;
        logic            xfer;
        logic [XY_W:0]   x_step;

        assign xfer   = gnt_valid && (gnt_idx == CH_W'(gi));
        assign x_step = {1'b0, x_q} + (XY_W+1)'(N_CH);

        always_ff @(posedge clk_i or posedge reset_i) begin
            if (reset_i) begin
                x_q    <= XY_W'(gi);
                y_q    <= '0;
                done_q <= 1'b0;
            end else begin
                done_q <= 1'b0;
                if (xfer) begin
                    if (x_step >= (XY_W+1)'(H_RES)) begin
                        x_q <= XY_W'(gi);
                        if (y_q == XY_W'(V_RES - 1)) begin
                            y_q    <= '0;
                            done_q <= 1'b1;
                        end else begin
                            y_q <= y_q + XY_W'(1);
                        end
                    end else begin
                        x_q <= x_step[XY_W-1:0];
                    end
                end
            end
        end

        assign cur_x[gi]                    = x_q;
        assign cur_y[gi]                    = y_q;
        assign ch_x_o[gi*XY_W +: XY_W]      = x_q;
        assign ch_y_o[gi*XY_W +: XY_W]      = y_q;
        assign frame_done_o[gi]             = done_q;
    end

endmodule

// File: tb/tb_fb_slot_arbiter.sv
// Directed bench for fb_slot_arbiter (N_CH=2, H_RES=640); V_RES is shortened so the
// end-of-frame wrap is reachable in a few thousand cycles.
module tb_fb_slot_arbiter;

    localparam int H_RES = 640;
    localparam int V_RES = 4;
    localparam int PIX_W = 4;
    localparam int N_CH  = 2;
    localparam int ADDR_W = 19;
    localparam int XY_W  = 10;

    logic                  clk = 1'b0;
    logic                  reset;
    logic [XY_W-1:0]       draw_x, draw_y;
    logic [PIX_W-1:0]      pix_out;
    logic [N_CH-1:0]       wr_valid;
    logic [N_CH*PIX_W-1:0] wr_data;
    logic [N_CH-1:0]       wr_ready;
    logic [N_CH*XY_W-1:0]  ch_x, ch_y;
    logic [N_CH-1:0]       frame_done;
    logic [ADDR_W-1:0]     mem_addr;
    logic [PIX_W-1:0]      mem_wdata;
    logic                  mem_we;
    logic [PIX_W-1:0]      mem_rdata;

    int checks = 0;
    int failures = 0;
    int tp = 0;

    fb_slot_arbiter #(
        .H_RES(H_RES), .V_RES(V_RES), .PIX_W(PIX_W),
        .N_CH(N_CH), .ADDR_W(ADDR_W), .XY_W(XY_W)
    ) dut (
        .clk_i(clk), .reset_i(reset),
        .draw_x_i(draw_x), .draw_y_i(draw_y), .pix_out_o(pix_out),
        .wr_valid_i(wr_valid), .wr_data_i(wr_data), .wr_ready_o(wr_ready),
        .ch_x_o(ch_x), .ch_y_o(ch_y), .frame_done_o(frame_done),
        .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata), .mem_we_o(mem_we),
        .mem_rdata_i(mem_rdata)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        tp = (tp + 1) % 4;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        #2;
        reset = 1'b0;
        #1;
        tp = 0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [PIX_W-1:0] pix_exp;
        logic [PIX_W-1:0] pix_nxt;
        int n;
        int fd_seen;
        int j;
        logic [1:0]       exp_rdy [6];
        logic [PIX_W-1:0] exp_wd  [6];
        exp_rdy = '{2'b01, 2'b10, 2'b01, 2'b10, 2'b01, 2'b10};
        exp_wd  = '{4'hA, 4'h5, 4'hA, 4'h5, 4'hA, 4'h5};

        reset = 1'b1; wr_valid = '0; wr_data = '0;
        draw_x = 10'd5; draw_y = 10'd2; mem_rdata = '0;
        repeat (2) @(posedge clk);
        #1;

        // Reset state
        check("rst_pix_out", 32'(pix_out), 0);
        check("rst_wr_ready", 32'(wr_ready), 0);
        check("rst_mem_we", 32'(mem_we), 0);
        check("rst_frame_done", 32'(frame_done), 0);
        check("rst_ch_x", 32'(ch_x), 32'd1024);
        check("rst_ch_y", 32'(ch_y), 0);
        check("rst_read_addr", 32'(mem_addr), 1285);
        $display("txn reset: ch_x=%0h ch_y=%0h addr=%0d", ch_x, ch_y, mem_addr);

        reset = 1'b0;
        tp = 0;
        pix_exp = '0;

        // Display-only traffic
        for (int i = 0; i < 12; i++) begin
            mem_rdata = 4'(i * 3 + 1);
            #1;
            check("rd_addr", 32'(mem_addr), (tp == 0) ? 32'd1285 : 32'd0);
            check("rd_no_we", 32'(mem_we), 0);
            check("rd_pix_out", 32'(pix_out), 32'(pix_exp));
            $display("txn read: phase=%0d addr=%0d pix_out=%0h", tp, mem_addr, pix_out);
            pix_nxt = pix_exp;
            if (tp == 1) pix_nxt = mem_rdata;
            tick();
            pix_exp = pix_nxt;
        end

        // Single channel 0 writer
        wr_valid = 2'b01;
        wr_data  = {4'h0, 4'hA};
        #1;
        check("ch0_p0_ready", 32'(wr_ready), 0);
        check("ch0_p0_we", 32'(mem_we), 0);
        tick();
        check("ch0_w1_ready", 32'(wr_ready), 1);
        check("ch0_w1_we", 32'(mem_we), 1);
        check("ch0_w1_addr", 32'(mem_addr), 0);
        check("ch0_w1_data", 32'(mem_wdata), 32'hA);
        $display("txn write: ch=0 addr=%0d data=%0h", mem_addr, mem_wdata);
        tick();
        check("ch0_x_after1", 32'(ch_x[9:0]), 2);
        check("ch1_x_stays", 32'(ch_x[19:10]), 1);
        check("ch0_w2_addr", 32'(mem_addr), 2);
        $display("txn write: ch=0 addr=%0d data=%0h", mem_addr, mem_wdata);
        tick();
        check("ch0_w3_addr", 32'(mem_addr), 4);
        check("ch0_w3_ready", 32'(wr_ready), 1);
        $display("txn write: ch=0 addr=%0d data=%0h", mem_addr, mem_wdata);
        tick();
        check("ch0_gap_ready", 32'(wr_ready), 0);
        check("ch0_gap_we", 32'(mem_we), 0);
        check("ch0_gap_addr", 32'(mem_addr), 1285);
        tick();
        check("ch0_w4_addr", 32'(mem_addr), 6);
        $display("txn write: ch=0 addr=%0d data=%0h", mem_addr, mem_wdata);
        wr_valid = '0;
        tick();

        // Both channels contending
        do_reset();
        wr_valid = 2'b11;
        wr_data  = {4'h5, 4'hA};
        j = 0;
        for (int cyc = 0; cyc < 8; cyc++) begin
            tick();
            if (tp == 0) begin
                check("rr_gap_we", 32'(mem_we), 0);
            end else begin
                check("rr_ready", 32'(wr_ready), 32'(exp_rdy[j]));
                check("rr_addr", 32'(mem_addr), 32'(j));
                check("rr_data", 32'(mem_wdata), 32'(exp_wd[j]));
                $display("txn rr: phase=%0d ready=%b addr=%0d data=%0h", tp, wr_ready, mem_addr, mem_wdata);
                j++;
            end
        end

        // Channel 0 runs to the end of the frame
        wr_valid = '0;
        do_reset();
        wr_valid = 2'b01;
        wr_data  = {4'h0, 4'h3};
        n = 0;
        fd_seen = 0;
        for (int i = 0; i < 3000 && n < (H_RES / N_CH) * V_RES - 1; i++) begin
            #1;
            if (wr_ready[0]) n++;
            if (frame_done[0]) fd_seen++;
            tick();
        end
        check("frame_prefill_count", 32'(n), 32'((H_RES / N_CH) * V_RES - 1));
        check("frame_no_early_done", 32'(fd_seen), 0);
        check("frame_last_x", 32'(ch_x[9:0]), 638);
        check("frame_last_y", 32'(ch_y[9:0]), V_RES - 1);
        n = 0;
        for (int i = 0; i < 4 && n == 0; i++) begin
            #1;
            if (wr_ready[0]) begin
                n = 1;
                check("frame_last_addr", 32'(mem_addr), 638 + H_RES * (V_RES - 1));
                $display("txn last: addr=%0d", mem_addr);
            end
            tick();
        end
        check("frame_last_found", 32'(n), 1);
        check("frame_wrap_x", 32'(ch_x[9:0]), 0);
        check("frame_wrap_y", 32'(ch_y[9:0]), 0);
        check("frame_done_pulse", 32'(frame_done), 1);
        tick();
        check("frame_done_clear", 32'(frame_done), 0);
        $display("txn frame_done: x=%0d y=%0d", ch_x[9:0], ch_y[9:0]);

        // Reset mid-frame during phase 2
        wr_valid = '0;
        do_reset();
        wr_valid = 2'b10;
        wr_data  = {4'h3, 4'h0};
        tick();
        check("r5_w1_ready", 32'(wr_ready), 2);
        check("r5_w1_addr", 32'(mem_addr), 1);
        tick();
        check("r5_w2_addr", 32'(mem_addr), 3);
        #2;
        reset = 1'b1;
        #1;
        check("r5_async_ready", 32'(wr_ready), 0);
        check("r5_async_we", 32'(mem_we), 0);
        check("r5_async_pix", 32'(pix_out), 0);
        check("r5_async_ch_x", 32'(ch_x), 32'd1024);
        check("r5_async_ch_y", 32'(ch_y), 0);
        check("r5_async_addr", 32'(mem_addr), 1285);
        @(posedge clk);
        #1;
        reset = 1'b0;
        tp = 0;
        #1;
        check("r5_p0_ready", 32'(wr_ready), 0);
        tick();
        check("r5_restart_ready", 32'(wr_ready), 2);
        check("r5_restart_addr", 32'(mem_addr), 1);
        $display("txn restart: ready=%b addr=%0d", wr_ready, mem_addr);

        // Valid held across the read slot
        wr_valid = '0;
        tick();
        tick();
        tick();
        wr_valid = 2'b01;
        wr_data  = {4'h0, 4'h7};
        #1;
        check("hold_p0_ready", 32'(wr_ready), 0);
        check("hold_p0_we", 32'(mem_we), 0);
        tick();
        check("hold_p1_ready", 32'(wr_ready), 1);
        check("hold_p1_data", 32'(mem_wdata), 7);
        check("hold_p1_addr", 32'(mem_addr), 0);
        $display("txn hold: ready=%b addr=%0d data=%0h", wr_ready, mem_addr, mem_wdata);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
